// File: rtl/chip8_mem_arbiter_if.sv
// rtl/chip8_mem_arbiter_if.sv - requester and memory-side signal bundle for chip8_mem_arbiter
//
// Purpose: groups the three requester ports (video, processor, debug) and the
// memory-side port of chip8_mem_arbiter. Directions in signal names are as
// seen from the arbiter.
// Modports:
//   slave  - the arbiter: takes requests and memory responses, drives
//            ready/valid pulses, shared response data and the memory request.
//   master - the surrounding system (requesters plus memory).

interface chip8_mem_arbiter_if;
  // video fetch (read only)
  logic        vid_valid_in;
  logic [11:0] vid_addr_in;
  logic        vid_ready_out;
  logic        vid_valid_out;
  // processor
  logic        proc_valid_in;
  logic [11:0] proc_addr_in;
  logic        proc_we_in;
  logic [15:0] proc_data_in;
  logic [1:0]  proc_type_in;
  logic        proc_size_in;
  logic        proc_ready_out;
  logic        proc_valid_out;
  // debug / host
  logic        dbg_valid_in;
  logic [11:0] dbg_addr_in;
  logic        dbg_we_in;
  logic [15:0] dbg_data_in;
  logic        dbg_ready_out;
  logic        dbg_valid_out;
  // shared response
  logic [15:0] data_out;
  logic        err_out;
  logic [1:0]  grant_out;
  // memory port
  logic [11:0] mem_addr_out;
  logic        mem_we_out;
  logic [15:0] mem_data_out;
  logic [1:0]  mem_type_out;
  logic        mem_size_out;
  logic        mem_valid_out;
  logic        mem_ready_in;
  logic        mem_valid_in;
  logic [15:0] mem_data_in;

  modport slave (
    input  vid_valid_in, vid_addr_in,
    output vid_ready_out, vid_valid_out,
    input  proc_valid_in, proc_addr_in, proc_we_in, proc_data_in, proc_type_in, proc_size_in,
    output proc_ready_out, proc_valid_out,
    input  dbg_valid_in, dbg_addr_in, dbg_we_in, dbg_data_in,
    output dbg_ready_out, dbg_valid_out,
    output data_out, err_out, grant_out,
    output mem_addr_out, mem_we_out, mem_data_out, mem_type_out, mem_size_out, mem_valid_out,
    input  mem_ready_in, mem_valid_in, mem_data_in
  );

  modport master (
    output vid_valid_in, vid_addr_in,
    input  vid_ready_out, vid_valid_out,
    output proc_valid_in, proc_addr_in, proc_we_in, proc_data_in, proc_type_in, proc_size_in,
    input  proc_ready_out, proc_valid_out,
    output dbg_valid_in, dbg_addr_in, dbg_we_in, dbg_data_in,
    input  dbg_ready_out, dbg_valid_out,
    input  data_out, err_out, grant_out,
    input  mem_addr_out, mem_we_out, mem_data_out, mem_type_out, mem_size_out, mem_valid_out,
    output mem_ready_in, mem_valid_in, mem_data_in
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - single-outstanding arbiter for the chip8_memory processor port
//
// Purpose: serialises video, processor and debug requests onto one memory
// port. Fixed priority vid > proc > dbg, except that a debug request pending
// STARVE_LIMIT cycles wins the next arbitration. A transaction not answered
// within TIMEOUT cycles of acceptance is aborted with data 16'hFFFF and err.
// Ports:
//   clk_in - system clock
//   rst_in - synchronous reset, active low
//   bus    - chip8_mem_arbiter_if.slave (requesters, response, memory port)

module chip8_mem_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  chip8_mem_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    grant_q;
  logic [11:0]   addr_q;
  logic          we_q;
  logic [15:0]   wdata_q;
  logic [1:0]    kind_q;
  logic          size_q;
  logic [15:0]   rdata_q;
  logic          vid_v_q, proc_v_q, dbg_v_q, err_q;

  logic       starved, tmo_hit, done, abort;
  logic [1:0] winner;

  assign starved = (starve_q == SW'(STARVE_LIMIT));
  // tmo_q counts edges already spent in ISSUE+WAIT, so the edge on which it
  // equals TIMEOUT-1 is the TIMEOUT-th edge after acceptance.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  // Winner is 0 when nobody may be accepted; readies are gated by reset so
  // every output is low while reset is held.
  always_comb begin
    winner = 2'd0;
    if (state_q == IDLE && rst_in) begin
      if (starved && bus.dbg_valid_in) winner = 2'd3;
      else if (bus.vid_valid_in)       winner = 2'd1;
      else if (bus.proc_valid_in)      winner = 2'd2;
      else if (bus.dbg_valid_in)       winner = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:  if (winner != 2'd0) state_d = ISSUE;
      // A timeout beats a simultaneous mem_ready_in in ISSUE; in WAIT a
      // response arriving on the timeout edge is still delivered.
      ISSUE: begin
        if (tmo_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (bus.mem_ready_in) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_valid_in) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      grant_q  <= 2'd0;
      addr_q   <= 12'd0;
      we_q     <= 1'b0;
      wdata_q  <= 16'd0;
      kind_q   <= 2'd0;
      size_q   <= 1'b0;
      rdata_q  <= 16'd0;
      vid_v_q  <= 1'b0;
      proc_v_q <= 1'b0;
      dbg_v_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vid_v_q  <= 1'b0;
      proc_v_q <= 1'b0;
      dbg_v_q  <= 1'b0;
      err_q    <= 1'b0;

      if (state_q != IDLE) tmo_q <= tmo_q + TW'(1);

      case (winner)
        2'd1: begin
          addr_q <= bus.vid_addr_in; we_q <= 1'b0; wdata_q <= 16'd0;
          kind_q <= 2'd0; size_q <= 1'b1;
        end
        2'd2: begin
          addr_q <= bus.proc_addr_in; we_q <= bus.proc_we_in; wdata_q <= bus.proc_data_in;
          kind_q <= bus.proc_type_in; size_q <= bus.proc_size_in;
        end
        2'd3: begin
          addr_q <= bus.dbg_addr_in; we_q <= bus.dbg_we_in; wdata_q <= bus.dbg_data_in;
          kind_q <= 2'd0; size_q <= 1'b1;
        end
        default: ;
      endcase
      if (winner != 2'd0) begin
        grant_q <= winner;
        tmo_q   <= '0;
      end

      if (done || abort) begin
        rdata_q  <= done ? bus.mem_data_in : 16'hFFFF;
        err_q    <= abort;
        vid_v_q  <= (grant_q == 2'd1);
        proc_v_q <= (grant_q == 2'd2);
        dbg_v_q  <= (grant_q == 2'd3);
        grant_q  <= 2'd0;
      end

      if (bus.dbg_valid_in && winner != 2'd3) begin
        if (!starved) starve_q <= starve_q + SW'(1);
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign bus.vid_ready_out  = (winner == 2'd1);
  assign bus.proc_ready_out = (winner == 2'd2);
  assign bus.dbg_ready_out  = (winner == 2'd3);
  assign bus.vid_valid_out  = vid_v_q;
  assign bus.proc_valid_out = proc_v_q;
  assign bus.dbg_valid_out  = dbg_v_q;
  assign bus.err_out        = err_q;
  assign bus.data_out       = rdata_q;
  assign bus.grant_out      = grant_q;
  assign bus.mem_valid_out  = (state_q == ISSUE);
  assign bus.mem_addr_out   = addr_q;
  assign bus.mem_we_out     = we_q;
  assign bus.mem_data_out   = wdata_q;
  assign bus.mem_type_out   = kind_q;
  assign bus.mem_size_out   = size_q;
endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the single processor-side port of chip8_memory among three requesters: video fetch, chip8_processor, and the debug/host port.
- Serialises transactions with one outstanding request at a time, using fixed priority plus a starvation guard for debug.
- Recovers from a memory port that never responds, via a timeout.
- Sits between chip8_processor, the video scanner, the debug bridge, and chip8_memory's proc_* interface.

Parameters:
- STARVE_LIMIT, 16: consecutive cycles debug may be pending unaccepted before it is promoted to top priority.
- TIMEOUT, 64: cycles allowed in ISSUE+WAIT before the transaction is aborted.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- vid_valid_in  in  1  video read request
- vid_addr_in  in  12  video read address
- vid_ready_out  out  1  video request accepted this cycle
- vid_valid_out  out  1  video read data valid, 1-cycle pulse
- proc_valid_in  in  1  processor request
- proc_addr_in  in  12  processor address
- proc_we_in  in  1  processor write enable
- proc_data_in  in  16  processor write data
- proc_type_in  in  2  processor transaction type, passed through
- proc_size_in  in  1  0 = byte, 1 = word
- proc_ready_out  out  1  processor request accepted
- proc_valid_out  out  1  processor response pulse
- dbg_valid_in  in  1  debug request
- dbg_addr_in  in  12  debug address
- dbg_we_in  in  1  debug write enable
- dbg_data_in  in  16  debug write data
- dbg_ready_out  out  1  debug request accepted
- dbg_valid_out  out  1  debug response pulse
- data_out  out  16  response data, shared by all requesters
- err_out  out  1  timeout pulse
- grant_out  out  2  current owner: 0 none, 1 vid, 2 proc, 3 dbg
- mem_addr_out  out  12  address to memory
- mem_we_out  out  1  write enable to memory
- mem_data_out  out  16  write data to memory
- mem_type_out  out  2  transaction type to memory
- mem_size_out  out  1  size to memory
- mem_valid_out  out  1  request valid to memory
- mem_ready_in  in  1  memory accepts request
- mem_valid_in  in  1  memory response; one pulse per transaction, reads and writes

Behaviour:
- Reset (rst_in low at a clock edge):
  - State becomes IDLE; counters and latched request cleared.
  - Every output is 0, including data_out and grant_out.
  - Reset mid-transaction aborts silently: no valid or err pulse.
- States: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational):
  - Order is dbg if starved, else vid > proc > dbg.
  - Exactly the winner's X_ready_out is high when state == IDLE; all ready outputs are low in ISSUE and WAIT.
  - Acceptance happens when X_valid_in && X_ready_out. The arbiter then:
    - latches addr, we, data, type and size;
    - sets grant_out;
    - moves to ISSUE.
- Per-requester field values:
  - vid: we=0, data=0, type=0, size=1.
  - dbg: type=0, size=1.
  - proc: all fields from its inputs.
- ISSUE:
  - mem_valid_out=1 with latched fields, held stable until mem_ready_in.
  - On mem_valid_out && mem_ready_in, go to WAIT.
- WAIT:
  - On mem_valid_in, capture mem_data_in into data_out.
  - Next cycle: pulse the owner's X_valid_out for exactly 1 cycle, grant_out returns to 0, state returns to IDLE.
  - data_out holds its value until the next capture.
- Latency:
  - Accept at T gives mem_valid_out at T+1.
  - With mem_ready_in at T+1, state is WAIT at T+2.
  - mem_valid_in at R gives X_valid_out at R+1.
  - Next acceptance is possible at R+1.
- Starvation counter:
  - Increments each cycle dbg_valid_in=1 and dbg is not accepted; saturates at STARVE_LIMIT.
  - Clears on dbg acceptance or when dbg_valid_in=0.
  - At STARVE_LIMIT, dbg wins the next IDLE arbitration regardless of vid and proc.
- Timeout:
  - A counter runs in ISSUE+WAIT and resets on leaving WAIT.
  - When it reaches TIMEOUT without mem_valid_in:
    - mem_valid_out drops;
    - data_out=16'hFFFF;
    - the owner's X_valid_out and err_out pulse together for 1 cycle;
    - state returns to IDLE.
- Stray inputs: mem_valid_in in IDLE or ISSUE is ignored; mem_ready_in outside ISSUE is ignored.
- A requester dropping valid after acceptance has no effect on the in-flight transaction.

Test Plan:
- Single proc read at 0x200 with memory returning 16'h00E0 two cycles after ready → proc_ready_out at T, mem_valid_out T+1, proc_valid_out one pulse with data_out=16'h00E0, grant_out 2 then 0.
- vid, proc and dbg all asserting in the same IDLE cycle → grants in order vid, proc, dbg; each valid_out pulses exactly once; no overlap of mem_valid_out transactions.
- vid and proc asserting continuously, dbg held with STARVE_LIMIT=16 → dbg accepted at the first IDLE after its counter reaches 16; counter then reads 0.
- proc write to 0x050 with mem_ready_in held low 5 cycles → mem_valid_out and fields stable all 5 cycles; a single acceptance; proc_valid_out pulses after mem_valid_in.
- Memory never responds, TIMEOUT=64 → exactly 64 cycles after acceptance, err_out and owner valid pulse once with data_out=16'hFFFF; next request is accepted normally.
- rst_in low during WAIT, then a late mem_valid_in after reset → all outputs 0; no valid pulse; state IDLE; the next request is served correctly.
